// File: rtl/genius_sequence_ctrl.sv
// Genius (Simon) game sequencer: seeds the PRNG, grows the color sequence, plays it out, checks presses.
// Optional macro GENIUS_TIMEOUT_EN adds a player inactivity timeout (TIMEOUT_CYCLES).
module genius_sequence_ctrl #(
   parameter int MAX_LEN        = 16,
   parameter int ON_CYCLES      = 4,
   parameter int OFF_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [3:0]                   seed,
   input  logic [1:0]                   rnd_in,
   output logic                         seed_load,
   output logic [3:0]                   seed_out,
   input  logic                         btn_valid,
   input  logic [1:0]                   btn_color,
   output logic                         led_en,
   output logic [1:0]                   led_color,
   output logic                         player_turn,
   output logic                         busy,
   output logic [$clog2(MAX_LEN+1)-1:0] round_len,
   output logic                         win,
   output logic                         fail
);

   localparam int RW = $clog2(MAX_LEN+1);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int T0 = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int T1 = (T0 > 2) ? T0 : 2;
`ifdef GENIUS_TIMEOUT_EN
   localparam int TMAX = (T1 > TIMEOUT_CYCLES) ? T1 : TIMEOUT_CYCLES;
`else
   localparam int TMAX = T1;
`endif
   localparam int TW = $clog2(TMAX+1);

   typedef enum logic [3:0] {
      IDLE, SEED, WARM, APPEND, PLAY_ON, PLAY_OFF, WAIT_IN, WIN, FAIL
   } state_t;

   state_t         state;
   logic [RW-1:0]  idx;
   logic [TW-1:0]  timer;
   logic [1:0]     mem [MAX_LEN];
   logic [RW-1:0]  idx_nx;
   logic [RW-1:0]  last_idx;

   assign seed_out = seed;
   assign idx_nx   = idx + RW'(1);
   assign last_idx = round_len - RW'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         round_len   <= '0;
         idx         <= '0;
         timer       <= '0;
         seed_load   <= 1'b0;
         led_en      <= 1'b0;
         led_color   <= 2'd0;
         player_turn <= 1'b0;
         busy        <= 1'b0;
         win         <= 1'b0;
         fail        <= 1'b0;
      end else begin
         seed_load <= 1'b0;
         case (state)
            IDLE, WIN, FAIL: begin
               if (start) begin
                  state     <= SEED;
                  win       <= 1'b0;
                  fail      <= 1'b0;
                  round_len <= '0;
                  seed_load <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            SEED: begin
               state <= WARM;
               timer <= '0;
            end
            WARM: begin
               if (timer == TW'(1)) begin
                  state <= APPEND;
                  timer <= '0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            APPEND: begin
               mem[round_len[AW-1:0]] <= rnd_in;
               round_len <= round_len + RW'(1);
               idx       <= '0;
               timer     <= '0;
               state     <= PLAY_ON;
               led_en    <= 1'b1;
               // slot 0 is being written this very cycle on the first round
               led_color <= (round_len == '0) ? rnd_in : mem[0];
            end
            PLAY_ON: begin
               if (timer == TW'(ON_CYCLES-1)) begin
                  state     <= PLAY_OFF;
                  timer     <= '0;
                  led_en    <= 1'b0;
                  led_color <= 2'd0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            PLAY_OFF: begin
               if (timer == TW'(OFF_CYCLES-1)) begin
                  timer <= '0;
                  if (idx == last_idx) begin
                     idx         <= '0;
                     state       <= WAIT_IN;
                     player_turn <= 1'b1;
                  end else begin
                     idx       <= idx_nx;
                     state     <= PLAY_ON;
                     led_en    <= 1'b1;
                     led_color <= mem[idx_nx[AW-1:0]];
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            WAIT_IN: begin
               if (btn_valid) begin
                  timer <= '0;
                  if (btn_color != mem[idx[AW-1:0]]) begin
                     state       <= FAIL;
                     fail        <= 1'b1;
                     player_turn <= 1'b0;
                     busy        <= 1'b0;
                  end else if (idx != last_idx) begin
                     idx <= idx_nx;
                  end else if (round_len == RW'(MAX_LEN)) begin
                     state       <= WIN;
                     win         <= 1'b1;
                     player_turn <= 1'b0;
                     busy        <= 1'b0;
                  end else begin
                     state       <= APPEND;
                     player_turn <= 1'b0;
                  end
               end
`ifdef GENIUS_TIMEOUT_EN
               else if (timer == TW'(TIMEOUT_CYCLES-1)) begin
                  state       <= FAIL;
                  fail        <= 1'b1;
                  player_turn <= 1'b0;
                  busy        <= 1'b0;
                  timer       <= '0;
               end else begin
                  timer <= timer + TW'(1);
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_genius_sequence_ctrl.sv
// Scoreboard bench for genius_sequence_ctrl: a queue-based game model predicts seed, flash, win and fail events.
module tb_genius_sequence_ctrl;

   localparam int ML  = 3;
   localparam int ON  = 4;
   localparam int OFF = 2;
   localparam int TO  = 8;
   localparam int EV_SEED = 0, EV_FLASH = 1, EV_WIN = 2, EV_FAIL = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] seed = 4'd0;
   logic [1:0] rnd_in = 2'd0;
   logic       seed_load;
   logic [3:0] seed_out;
   logic       btn_valid = 1'b0;
   logic [1:0] btn_color = 2'd0;
   logic       led_en;
   logic [1:0] led_color;
   logic       player_turn;
   logic       busy;
   logic [$clog2(ML+1)-1:0] round_len;
   logic       win;
   logic       fail;

   genius_sequence_ctrl #(.MAX_LEN(ML), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .rnd_in(rnd_in),
      .seed_load(seed_load), .seed_out(seed_out), .btn_valid(btn_valid), .btn_color(btn_color),
      .led_en(led_en), .led_color(led_color), .player_turn(player_turn), .busy(busy),
      .round_len(round_len), .win(win), .fail(fail)
   );

   always #5 clk = ~clk;

   typedef struct { int kind; int val; } ev_t;
   ev_t        exp_q[$];
   logic [1:0] seq[$];
   logic [1:0] plan [ML];
   int total = 0;
   int bad = 0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_ev(input int k, input int v);
      ev_t e;
      e.kind = k; e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic push_flashes();
      foreach (seq[i]) push_ev(EV_FLASH, int'(seq[i]));
   endtask

   // monitor: turns DUT activity into events and checks them against the scoreboard
   int cyc = 0, seed_cyc = 0, oncnt = 0, offcnt = 0;
   logic pl = 0, pp = 0, ps = 0, pw = 0, pf = 0, inp = 0, first_led = 0;
   logic [1:0] col = 0;

   task automatic pop_check(input string name, input int k, input int v);
      ev_t e;
      if (exp_q.size() == 0) begin
         total++; bad++;
         $display("FAIL %s: unexpected event kind=%0d val=%0d", name, k, v);
      end else begin
         e = exp_q.pop_front();
         check({name, "_kind"}, k, e.kind);
         check({name, "_val"}, v, e.val);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         pl = 0; pp = 0; ps = 0; pw = 0; pf = 0; inp = 0; first_led = 0; oncnt = 0;
      end else begin
         if (!led_en && led_color != 2'd0) check("led_color_dark", int'(led_color), 0);
         if (seed_load) begin
            if (ps) check("seed_load_width", 2, 1);
            pop_check("seed", EV_SEED, int'(seed_out));
            seed_cyc = cyc; first_led = 1; inp = 0;
         end
         if (player_turn && !pp) begin
            if (inp) check("last_off_len", offcnt, OFF);
            inp = 0;
         end
         if (led_en && !pl) begin
            if (first_led) check("start_latency", cyc - seed_cyc, 4);
            first_led = 0;
            if (inp) check("off_len", offcnt, OFF);
            col = led_color; oncnt = 1;
         end else if (led_en) begin
            oncnt++;
            if (led_color != col) check("led_color_stable", int'(led_color), int'(col));
         end
         if (!led_en && pl) begin
            check("on_len", oncnt, ON);
            pop_check("flash", EV_FLASH, int'(col));
            inp = 1; offcnt = 1;
         end else if (!led_en && inp) begin
            offcnt++;
         end
         if (win && !pw) begin
            pop_check("win", EV_WIN, 0);
            check("win_busy", int'(busy), 0);
            check("win_turn", int'(player_turn), 0);
         end
         if (fail && !pf) begin
            pop_check("fail", EV_FAIL, 0);
            check("fail_busy", int'(busy), 0);
            check("fail_turn", int'(player_turn), 0);
            check("fail_win", int'(win), 0);
         end
         pl = led_en; pp = player_turn; ps = seed_load; pw = win; pf = fail;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_turn(output logic ok);
      int n = 0;
      while (!player_turn && n < 300) begin tick(1); n++; end
      ok = player_turn;
      if (!ok) check("wait_turn_timeout", 0, 1);
   endtask

   task automatic press(input logic [1:0] c);
      tick(1);
      btn_valid = 1'b1; btn_color = c;
      tick(1);
      btn_valid = 1'b0;
   endtask

   task automatic do_start(input logic [3:0] sd);
      seed = sd;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check("start_clears_win", int'(win), 0);
      check("start_clears_fail", int'(fail), 0);
      check("start_busy", int'(busy), 1);
   endtask

   // fail_round > ML means the whole game is played correctly to a win
   task automatic run_game(input logic [3:0] sd, input int fail_round, input int fail_pos);
      logic ok;
      logic [1:0] c;
      seq.delete();
      rnd_in = plan[0];
      seq.push_back(plan[0]);
      push_ev(EV_SEED, int'(sd));
      push_flashes();
      do_start(sd);
      for (int r = 1; r <= ML; r++) begin
         wait_turn(ok);
         if (!ok) return;
         check("round_len", int'(round_len), r);
         for (int i = 0; i < r; i++) begin
            tick($urandom_range(0, 2));
            if (r == fail_round && i == fail_pos) begin
               c = seq[i] ^ 2'($urandom_range(1, 3));
               push_ev(EV_FAIL, 0);
               press(c);
               tick(2);
               check("fail_sticky", int'(fail), 1);
               return;
            end
            if (i == r - 1) begin
               if (r == ML) push_ev(EV_WIN, 0);
               else begin
                  rnd_in = plan[r];
                  seq.push_back(plan[r]);
                  push_flashes();
               end
            end
            press(seq[i]);
         end
      end
      tick(2);
      check("win_sticky", int'(win), 1);
   endtask

   task automatic wait_led(output logic ok);
      int n = 0;
      while (!led_en && n < 50) begin tick(1); n++; end
      ok = led_en;
      if (!ok) check("wait_led_timeout", 0, 1);
   endtask

   initial begin
      logic ok;
      int n;
      // reset then idle
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("idle_outputs", int'({seed_load, led_en, led_color, player_turn, busy, win, fail, round_len}), 0);
      end

      // start timing, first color 3, then a wrong press
      plan[0] = 2'd3; plan[1] = 2'd0; plan[2] = 2'd0;
      run_game(4'h9, 1, 0);

      // correct rounds 2,1,x through to a win
      plan[0] = 2'd2; plan[1] = 2'd1; plan[2] = 2'($urandom_range(0, 3));
      run_game(4'($urandom), ML + 1, 0);
      press(2'd0);
      tick(2);
      check("btn_in_win_win", int'(win), 1);
      check("btn_in_win_busy", int'(busy), 0);

      // wrong second press in round 2
      plan[0] = 2'd2; plan[1] = 2'd1; plan[2] = 2'd3;
      run_game(4'h5, 2, 1);

      // randomized games
      for (int g = 0; g < 8; g++) begin
         int fr;
         foreach (plan[i]) plan[i] = 2'($urandom_range(0, 3));
         fr = $urandom_range(1, ML + 1);
         run_game(4'($urandom), fr, (fr <= ML) ? $urandom_range(0, fr - 1) : 0);
      end

      // start during PLAY_ON is ignored
      plan[0] = 2'($urandom_range(0, 3));
      seq.delete(); seq.push_back(plan[0]);
      rnd_in = plan[0];
      push_ev(EV_SEED, 7); push_flashes();
      do_start(4'd7);
      wait_led(ok);
      seed = 4'd2; start = 1'b1; tick(1); start = 1'b0;
      wait_turn(ok);
      check("ignored_start_round_len", int'(round_len), 1);

`ifdef GENIUS_TIMEOUT_EN
      push_ev(EV_FAIL, 0);
      n = 0;
      while (!fail && n < 50) begin tick(1); n++; end
      check("timeout_cycles", n, TO);
`else
      tick(20);
      check("no_timeout_turn", int'(player_turn), 1);
      check("no_timeout_fail", int'(fail), 0);
      push_ev(EV_FAIL, 0);
      press(seq[0] ^ 2'd1);
      tick(2);
`endif

      // reset during PLAY_ON
      plan[0] = 2'd1;
      seq.delete(); seq.push_back(plan[0]);
      rnd_in = plan[0];
      push_ev(EV_SEED, 3); push_flashes();
      do_start(4'd3);
      wait_led(ok);
      rst_n = 1'b0;
      tick(1);
      exp_q.delete();
      check("reset_led_en", int'(led_en), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_round_len", int'(round_len), 0);
      rst_n = 1'b1;
      tick(5);
      check("after_reset_idle", int'({busy, led_en, player_turn, seed_load}), 0);

      tick(3);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
